// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init/refresh sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWR   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } lcd_state_t;

  // Writer data-mux select codes
  localparam logic [1:0] MUX_INIT = 2'b00;
  localparam logic [1:0] MUX_ADDR = 2'b01;
  localparam logic [1:0] MUX_CHAR = 2'b10;

  // LCD register-select levels
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_dly_cnt.sv
// Loadable down-counter shared by the power-up wait, the execution gap
// and the write timeout. Load wins over enable; the count parks at zero.
module lcd_dly_cnt #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  // Count register: load, else decrement until terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD init/refresh sequencer. Walks either the init command list or a
// full-screen refresh (address command + LINE_LEN chars per line), handing
// one byte at a time to the writer and pacing it with gap and timeout timers.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for lcd_enable; mode captured on acceptance
// PWR   | power-up wait of PWR_CYC cycles before the first init command
// ISSUE | single-cycle wr_start for the current item
// WAIT  | waiting for wr_done, bounded by TO_CYC cycles
// GAP   | GAP_CYC cycles of LCD execution time, then advance the item
// DONE  | one-cycle lcd_finish
// ERR   | one-cycle lcd_err after a write timeout
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int N_INIT   = 4,
  parameter int N_LINES  = 2,
  parameter int LINE_LEN = 16,
  parameter int GAP_CYC  = 3,
  parameter int PWR_CYC  = 10,
  parameter int TO_CYC   = 50,
  parameter int DLY_W    = 16,
  parameter int IDX_W    = $clog2((N_INIT > N_LINES * LINE_LEN) ? N_INIT : N_LINES * LINE_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_enable,
  input  logic             mode,
  input  logic             wr_done,
  output logic             wr_start,
  output logic             wr_rs,
  output logic [1:0]       mux_sel,
  output logic [IDX_W-1:0] item_idx,
  output logic             busy,
  output logic             lcd_finish,
  output logic             lcd_err
);

  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_INIT - 1);
  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(N_LINES - 1);
  localparam logic [IDX_W-1:0] LAST_CHAR = IDX_W'(LINE_LEN - 1);

  lcd_state_t state, state_nxt;

  logic             mode_r;     // 0 = init run, 1 = refresh run
  logic             addr_ph;    // refresh: address item of current line is next
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] line_idx;
  logic [IDX_W-1:0] char_idx;   // position within the line, wraps at LINE_LEN
  logic [IDX_W-1:0] char_addr;  // running char buffer address across lines

  logic             accept;
  logic             advance;
  logic             last_item;
  logic             dly_load;
  logic [DLY_W-1:0] dly_val;
  logic             dly_en;
  logic             dly_zero;

  lcd_dly_cnt #(
    .DLY_W(DLY_W)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .load    (dly_load),
    .load_val(dly_val),
    .en      (dly_en),
    .zero    (dly_zero)
  );

  assign last_item = mode_r ? (!addr_ph && (char_idx == LAST_CHAR) && (line_idx == LAST_LINE))
                            : (init_idx == LAST_INIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and timer control; timers are loaded with N-1 so a state
  // lasts exactly N cycles when it exits on the zero flag
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    dly_load  = 1'b0;
    dly_val   = '0;
    dly_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lcd_enable) begin
          accept = 1'b1;
          if (!mode) begin
            state_nxt = ST_PWR;
            dly_load  = 1'b1;
            dly_val   = DLY_W'(PWR_CYC - 1);
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_PWR: begin
        if (dly_zero) state_nxt = ST_ISSUE;
        else          dly_en    = 1'b1;
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        dly_load  = 1'b1;
        dly_val   = DLY_W'(TO_CYC - 1);
      end
      ST_WAIT: begin
        // wr_done is checked first so a reply on the expiry cycle still wins
        if (wr_done) begin
          state_nxt = ST_GAP;
          dly_load  = 1'b1;
          dly_val   = DLY_W'(GAP_CYC - 1);
        end else if (dly_zero) begin
          state_nxt = ST_ERR;
        end else begin
          dly_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (dly_zero) begin
          if (last_item) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ISSUE;
            advance   = 1'b1;
          end
        end else begin
          dly_en = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Item indices: cleared on acceptance, stepped only at the end of GAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= 1'b0;
      addr_ph   <= 1'b0;
      init_idx  <= '0;
      line_idx  <= '0;
      char_idx  <= '0;
      char_addr <= '0;
    end else if (accept) begin
      mode_r    <= mode;
      addr_ph   <= mode;
      init_idx  <= '0;
      line_idx  <= '0;
      char_idx  <= '0;
      char_addr <= '0;
    end else if (advance) begin
      if (!mode_r) begin
        init_idx <= init_idx + 1'b1;
      end else if (addr_ph) begin
        addr_ph <= 1'b0;
      end else begin
        char_addr <= char_addr + 1'b1;
        if (char_idx == LAST_CHAR) begin
          char_idx <= '0;
          line_idx <= line_idx + 1'b1;
          addr_ph  <= 1'b1;
        end else begin
          char_idx <= char_idx + 1'b1;
        end
      end
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    wr_start   = (state == ST_ISSUE);
    busy       = (state != ST_IDLE);
    lcd_finish = (state == ST_DONE);
    lcd_err    = (state == ST_ERR);
  end

  // Writer selects, driven from registered indices so they stay put
  // from ISSUE through WAIT and GAP
  always_comb begin
    if (!mode_r) begin
      mux_sel  = MUX_INIT;
      wr_rs    = RS_CMD;
      item_idx = init_idx;
    end else if (addr_ph) begin
      mux_sel  = MUX_ADDR;
      wr_rs    = RS_CMD;
      item_idx = line_idx;
    end else begin
      mux_sel  = MUX_CHAR;
      wr_rs    = RS_DATA;
      item_idx = char_addr;
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl against a list/arithmetic model of
// the item order and handshake timing.
`timescale 1ns/1ps
module tb_lcd_seq_ctrl;

  localparam int N_INIT   = 4;
  localparam int N_LINES  = 2;
  localparam int LINE_LEN = 16;
  localparam int GAP_CYC  = 3;
  localparam int PWR_CYC  = 10;
  localparam int TO_CYC   = 50;
  localparam int IW       = $clog2((N_INIT > N_LINES * LINE_LEN) ? N_INIT : N_LINES * LINE_LEN);
  localparam int MAXI     = 64;
  localparam int MAX_CYC  = 4000;

  typedef logic [IW+2:0] item_t;  // {mux_sel, wr_rs, item_idx}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lcd_enable = 1'b0;
  logic mode = 1'b0;
  logic wr_done = 1'b0;
  logic wr_start, wr_rs, busy, lcd_finish, lcd_err;
  logic [1:0] mux_sel;
  logic [IW-1:0] item_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model
  item_t exp_item[MAXI];
  int    exp_cyc[MAXI];
  int    exp_n, exp_fin, exp_err;
  int    lat[MAXI];      // writer latency per start; 0 = never answers
  int    lat_s2[MAXI];

  // observations
  item_t obs_item[MAXI];
  int    obs_cyc[MAXI];
  int    obs_n, fin_cnt, fin_cyc, err_cnt, err_cyc;
  int    busy_low, stab_err, extra_pulse, busy_after, timed_out;

  lcd_seq_ctrl #(
    .N_INIT(N_INIT), .N_LINES(N_LINES), .LINE_LEN(LINE_LEN),
    .GAP_CYC(GAP_CYC), .PWR_CYC(PWR_CYC), .TO_CYC(TO_CYC), .DLY_W(16)
  ) dut (
    .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .mode(mode), .wr_done(wr_done),
    .wr_start(wr_start), .wr_rs(wr_rs), .mux_sel(mux_sel), .item_idx(item_idx),
    .busy(busy), .lcd_finish(lcd_finish), .lcd_err(lcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected item list and cycle timeline, relative to the enable cycle 0
  function automatic void build_model(input bit m);
    int n = 0;
    int t;
    if (!m) begin
      for (int i = 0; i < N_INIT; i++) begin
        exp_item[n] = {2'b00, 1'b0, IW'(i)};
        n++;
      end
    end else begin
      for (int l = 0; l < N_LINES; l++) begin
        exp_item[n] = {2'b01, 1'b0, IW'(l)};
        n++;
        for (int c = 0; c < LINE_LEN; c++) begin
          exp_item[n] = {2'b10, 1'b1, IW'(l * LINE_LEN + c)};
          n++;
        end
      end
    end
    t = m ? 1 : 1 + PWR_CYC;
    exp_n = 0; exp_fin = -1; exp_err = -1;
    for (int k = 0; k < n; k++) begin
      exp_cyc[k] = t;
      exp_n = k + 1;
      if (lat[k] == 0 || lat[k] > TO_CYC) begin
        exp_err = t + 1 + TO_CYC;
        break;
      end
      t = t + lat[k] + GAP_CYC + 1;
    end
    if (exp_err < 0) exp_fin = t;
  endfunction

  // Runs one request starting in the current (IDLE) cycle, acting as the
  // writer; ends in the IDLE cycle after DONE/ERR so a new run can follow.
  task automatic drive_run(input bit m, input bit spur);
    int    cyc = 0;
    int    done_at = -1;
    int    last_done = -1000;
    int    end_cyc = -1;
    item_t ref_item = '0;
    item_t cur;
    obs_n = 0; fin_cnt = 0; fin_cyc = -1; err_cnt = 0; err_cyc = -1;
    busy_low = 0; stab_err = 0; extra_pulse = 0; busy_after = 1; timed_out = 0;
    lcd_enable = 1'b1; mode = m; wr_done = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      lcd_enable = 1'b0; mode = 1'b0; wr_done = 1'b0;
      cur = {mux_sel, wr_rs, item_idx};
      if (end_cyc >= 0 && cyc == end_cyc + 1) begin
        busy_after = int'(busy);
        if (lcd_finish || lcd_err) extra_pulse++;
        break;
      end
      if (wr_start) begin
        if (obs_n < MAXI) begin
          obs_item[obs_n] = cur;
          obs_cyc[obs_n]  = cyc;
          if (lat[obs_n] != 0) done_at = cyc + lat[obs_n];
        end
        ref_item = cur;
        obs_n++;
      end else if (obs_n > 0 && cur !== ref_item) begin
        stab_err++;
      end
      if (busy !== 1'b1) busy_low++;
      if (lcd_finish) begin fin_cnt++; fin_cyc = cyc; end_cyc = cyc; end
      if (lcd_err)    begin err_cnt++; err_cyc = cyc; end_cyc = cyc; end
      if (cyc == done_at) begin
        wr_done = 1'b1;
        last_done = cyc;
      end else if (spur && cyc > last_done && cyc <= last_done + GAP_CYC && $urandom_range(0, 1) == 1) begin
        wr_done = 1'b1;
      end
      if (spur && end_cyc < 0 && $urandom_range(0, 3) == 0) begin
        lcd_enable = 1'b1;
        mode = 1'($urandom_range(0, 1));
      end
      if (cyc >= MAX_CYC) begin timed_out = 1; break; end
    end
    lcd_enable = 1'b0; wr_done = 1'b0; mode = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want all zero",
               {wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err} !== '0) begin
      n_fail++;
      $display("FAIL idle after reset: got %b want all zero",
               {wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err});
    end
  endtask

  task automatic test_init();
    for (int k = 0; k < MAXI; k++) lat[k] = 2;
    build_model(1'b0);
    drive_run(1'b0, 1'b0);
    n_checks++;
    if (obs_cyc[0] !== 11) begin n_fail++; $display("FAIL init first start cycle: got %0d want 11", obs_cyc[0]); end
    n_checks++;
    if (obs_n !== exp_n) begin n_fail++; $display("FAIL init start count: got %0d want %0d", obs_n, exp_n); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k]) begin n_fail++; $display("FAIL init item[%0d]: got %h want %h", k, obs_item[k], exp_item[k]); end
      n_checks++;
      if (obs_cyc[k] !== exp_cyc[k]) begin n_fail++; $display("FAIL init start cycle[%0d]: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0) begin
      n_fail++; $display("FAIL init finish: got cnt=%0d cyc=%0d err=%0d want cnt=1 cyc=%0d err=0", fin_cnt, fin_cyc, err_cnt, exp_fin);
    end
    n_checks++;
    if (busy_low !== 0 || busy_after !== 0 || stab_err !== 0 || extra_pulse !== 0 || timed_out !== 0) begin
      n_fail++; $display("FAIL init status: busy_low=%0d busy_after=%0d stab=%0d extra=%0d to=%0d want all 0",
                         busy_low, busy_after, stab_err, extra_pulse, timed_out);
    end
  endtask

  task automatic test_refresh();
    for (int k = 0; k < MAXI; k++) begin lat[k] = int'($urandom_range(1, 6)); lat_s2[k] = lat[k]; end
    build_model(1'b1);
    drive_run(1'b1, 1'b0);
    n_checks++;
    if (obs_n !== N_LINES * (LINE_LEN + 1)) begin n_fail++; $display("FAIL refresh start count: got %0d want %0d", obs_n, N_LINES * (LINE_LEN + 1)); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k]) begin n_fail++; $display("FAIL refresh item[%0d]: got %h want %h", k, obs_item[k], exp_item[k]); end
      n_checks++;
      if (obs_cyc[k] !== exp_cyc[k]) begin n_fail++; $display("FAIL refresh start cycle[%0d]: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0) begin
      n_fail++; $display("FAIL refresh finish: got cnt=%0d cyc=%0d err=%0d want cnt=1 cyc=%0d err=0", fin_cnt, fin_cyc, err_cnt, exp_fin);
    end
    n_checks++;
    if (busy_low !== 0 || busy_after !== 0 || stab_err !== 0 || extra_pulse !== 0 || timed_out !== 0) begin
      n_fail++; $display("FAIL refresh status: busy_low=%0d busy_after=%0d stab=%0d extra=%0d to=%0d want all 0",
                         busy_low, busy_after, stab_err, extra_pulse, timed_out);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < MAXI; k++) lat[k] = int'($urandom_range(1, 5));
    lat[2] = 0;
    build_model(1'b1);
    drive_run(1'b1, 1'b0);
    n_checks++;
    if (obs_n !== 3) begin n_fail++; $display("FAIL timeout start count: got %0d want 3", obs_n); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k] || obs_cyc[k] !== exp_cyc[k]) begin
        n_fail++; $display("FAIL timeout start[%0d]: got %h@%0d want %h@%0d", k, obs_item[k], obs_cyc[k], exp_item[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (err_cnt !== 1 || err_cyc !== exp_err || fin_cnt !== 0) begin
      n_fail++; $display("FAIL timeout err: got cnt=%0d cyc=%0d fin=%0d want cnt=1 cyc=%0d fin=0", err_cnt, err_cyc, fin_cnt, exp_err);
    end
    n_checks++;
    if (busy_after !== 0 || busy_low !== 0 || extra_pulse !== 0 || timed_out !== 0) begin
      n_fail++; $display("FAIL timeout status: busy_after=%0d busy_low=%0d extra=%0d to=%0d want all 0", busy_after, busy_low, extra_pulse, timed_out);
    end
    // restart straight from the IDLE cycle after ERR
    for (int k = 0; k < MAXI; k++) lat[k] = int'($urandom_range(1, 4));
    build_model(1'b1);
    drive_run(1'b1, 1'b0);
    n_checks++;
    if (obs_n < 1 || obs_item[0] !== {2'b01, 1'b0, IW'(0)} || obs_cyc[0] !== 1) begin
      n_fail++; $display("FAIL timeout restart first: got n=%0d %h@%0d want line 0 address at 1", obs_n, obs_item[0], obs_cyc[0]);
    end
    n_checks++;
    if (obs_n !== exp_n || fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0) begin
      n_fail++; $display("FAIL timeout restart run: got n=%0d fin=%0d@%0d err=%0d want n=%0d fin=1@%0d err=0",
                         obs_n, fin_cnt, fin_cyc, err_cnt, exp_n, exp_fin);
    end
  endtask

  task automatic test_ignored();
    for (int k = 0; k < MAXI; k++) lat[k] = lat_s2[k];
    build_model(1'b1);
    drive_run(1'b1, 1'b1);
    n_checks++;
    if (obs_n !== exp_n) begin n_fail++; $display("FAIL ignored start count: got %0d want %0d", obs_n, exp_n); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k]) begin n_fail++; $display("FAIL ignored item[%0d]: got %h want %h", k, obs_item[k], exp_item[k]); end
      n_checks++;
      if (obs_cyc[k] !== exp_cyc[k]) begin n_fail++; $display("FAIL ignored start cycle[%0d]: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0) begin
      n_fail++; $display("FAIL ignored finish: got cnt=%0d cyc=%0d err=%0d want cnt=1 cyc=%0d err=0", fin_cnt, fin_cyc, err_cnt, exp_fin);
    end
    n_checks++;
    if (busy_low !== 0 || busy_after !== 0 || stab_err !== 0 || timed_out !== 0) begin
      n_fail++; $display("FAIL ignored status: busy_low=%0d busy_after=%0d stab=%0d to=%0d want all 0", busy_low, busy_after, stab_err, timed_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < MAXI; k++) lat[k] = int'($urandom_range(1, 3));
    drive_run(1'b1, 1'b0);
    n_checks++;
    if (fin_cnt !== 1) begin n_fail++; $display("FAIL b2b first run finish: got %0d want 1", fin_cnt); end
    for (int k = 0; k < MAXI; k++) lat[k] = int'($urandom_range(1, 8));
    build_model(1'b0);
    drive_run(1'b0, 1'b0);
    n_checks++;
    if (obs_n !== exp_n) begin n_fail++; $display("FAIL b2b start count: got %0d want %0d", obs_n, exp_n); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k] || obs_cyc[k] !== exp_cyc[k]) begin
        n_fail++; $display("FAIL b2b start[%0d]: got %h@%0d want %h@%0d", k, obs_item[k], obs_cyc[k], exp_item[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc !== exp_fin || busy_after !== 0 || stab_err !== 0) begin
      n_fail++; $display("FAIL b2b finish: got cnt=%0d cyc=%0d busy_after=%0d stab=%0d want 1/%0d/0/0", fin_cnt, fin_cyc, busy_after, stab_err, exp_fin);
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k < MAXI; k++) lat[k] = int'($urandom_range(1, 4));
    lat[0] = TO_CYC;
    lat[3] = TO_CYC;
    build_model(1'b0);
    drive_run(1'b0, 1'b0);
    n_checks++;
    if (obs_n !== exp_n || fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0) begin
      n_fail++; $display("FAIL boundary on-time: got n=%0d fin=%0d@%0d err=%0d want n=%0d fin=1@%0d err=0",
                         obs_n, fin_cnt, fin_cyc, err_cnt, exp_n, exp_fin);
    end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_cyc[k] !== exp_cyc[k]) begin n_fail++; $display("FAIL boundary start cycle[%0d]: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    // one cycle too late is a timeout
    for (int k = 0; k < MAXI; k++) lat[k] = 2;
    lat[1] = TO_CYC + 1;
    build_model(1'b0);
    drive_run(1'b0, 1'b0);
    n_checks++;
    if (obs_n !== 2 || err_cnt !== 1 || err_cyc !== exp_err || fin_cnt !== 0 || busy_after !== 0) begin
      n_fail++; $display("FAIL boundary late: got n=%0d err=%0d@%0d fin=%0d busy_after=%0d want n=2 err=1@%0d fin=0 busy_after=0",
                         obs_n, err_cnt, err_cyc, fin_cnt, busy_after, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int done_at = -1;
    int bad = 0;
    bit hit = 1'b0;
    lcd_enable = 1'b1; mode = 1'b1;
    while (cyc < 2000 && !hit) begin
      @(posedge clk); #1;
      cyc++;
      lcd_enable = 1'b0; mode = 1'b0; wr_done = 1'b0;
      if (wr_start) begin
        if (mux_sel === 2'b10 && item_idx === IW'(20)) hit = 1'b1;
        else done_at = cyc + 2;
      end
      if (cyc == done_at) wr_done = 1'b1;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL rstmid reach char 20: got not reached want reached"); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid async clear: got %b want all zero",
               {wr_start, wr_rs, mux_sel, item_idx, busy, lcd_finish, lcd_err});
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (lcd_finish || lcd_err || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid during reset: got %0d active cycles want 0", bad); end
    rst = 1'b0;
    for (int k = 0; k < MAXI; k++) lat[k] = 2;
    build_model(1'b0);
    drive_run(1'b0, 1'b0);
    n_checks++;
    if (obs_n !== exp_n) begin n_fail++; $display("FAIL rstmid init count: got %0d want %0d", obs_n, exp_n); end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_item[k] !== exp_item[k] || obs_cyc[k] !== exp_cyc[k]) begin
        n_fail++; $display("FAIL rstmid init start[%0d]: got %h@%0d want %h@%0d", k, obs_item[k], obs_cyc[k], exp_item[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc !== exp_fin || err_cnt !== 0 || busy_after !== 0) begin
      n_fail++; $display("FAIL rstmid init finish: got cnt=%0d cyc=%0d err=%0d busy_after=%0d want 1/%0d/0/0",
                         fin_cnt, fin_cyc, err_cnt, busy_after, exp_fin);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh();
    test_timeout();
    test_ignored();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
